dmem_arbiter: RTL and testbench

//   Shares the single-port Data_Memory between the CPU MEM stage and a debug/loader port.

---
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage and a debug/loader port.
// Optional `DMEM_ARB_STATS_EN adds saturating stall-cycle and debug-grant counters.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              cpu_memread_i,
  input  logic              cpu_memwrite_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              dbg_valid_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_ready_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
`ifdef DMEM_ARB_STATS_EN
  output logic [15:0]       cpu_stall_cnt_o,
  output logic [15:0]       dbg_grant_cnt_o,
`endif
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StCpuRd = 2'd1;
  localparam logic [1:0] StDbgRd = 2'd2;

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  logic [1:0]        state_q, state_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;

  logic cpu_req;
  logic dbg_win;

  assign cpu_req = start_i && (cpu_memread_i || cpu_memwrite_i);
  assign dbg_win = dbg_valid_i && (!cpu_req || (wait_cnt_q == MaxWait));

  // Outputs are forced quiet while reset is asserted so nothing issues in a reset cycle.
  always_comb begin
    state_d      = state_q;
    dbg_ready_o  = 1'b0;
    dbg_rvalid_o = 1'b0;
    cpu_stall_o  = 1'b0;
    mem_en_o     = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    cpu_rdata_o  = cpu_rdata_q;
    dbg_rdata_o  = dbg_rdata_q;
    if (!rst_i) begin
      case (state_q)
        StIdle: begin
          if (dbg_win) begin
            dbg_ready_o = 1'b1;
            cpu_stall_o = cpu_req;
            mem_en_o    = 1'b1;
            mem_we_o    = dbg_we_i;
            mem_addr_o  = dbg_addr_i;
            mem_wdata_o = dbg_wdata_i;
            if (!dbg_we_i) state_d = StDbgRd;
          end else if (cpu_req) begin
            mem_en_o    = 1'b1;
            mem_we_o    = cpu_memwrite_i;
            mem_addr_o  = cpu_addr_i;
            mem_wdata_o = cpu_wdata_i;
            if (!cpu_memwrite_i) begin
              cpu_stall_o = 1'b1;
              state_d     = StCpuRd;
            end
          end
        end
        StCpuRd: begin
          cpu_rdata_o = mem_rdata_i;
          state_d     = StIdle;
        end
        StDbgRd: begin
          dbg_rvalid_o = 1'b1;
          dbg_rdata_o  = mem_rdata_i;
          cpu_stall_o  = cpu_req;
          state_d      = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!dbg_valid_i || dbg_ready_o) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < MaxWait) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      cpu_rdata_q <= cpu_rdata_o;
      dbg_rdata_q <= dbg_rdata_o;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall_cnt_q, grant_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      grant_cnt_q <= '0;
    end else begin
      if (cpu_stall_o && (stall_cnt_q != 16'hffff)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (dbg_valid_i && dbg_ready_o && (grant_cnt_q != 16'hffff)) begin
        grant_cnt_q <= grant_cnt_q + 16'd1;
      end
    end
  end

  assign cpu_stall_cnt_o = stall_cnt_q;
  assign dbg_grant_cnt_o = grant_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (MAX_WAIT = 4).
// Build with +define+DMEM_ARB_STATS_EN to also check the statistics counters.
module tb_dmem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        cpu_memread_i, cpu_memwrite_i;
  logic [31:0] cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
  logic        cpu_stall_o;
  logic        dbg_valid_i, dbg_we_i;
  logic [31:0] dbg_addr_i, dbg_wdata_i, dbg_rdata_o;
  logic        dbg_ready_o, dbg_rvalid_o;
  logic        mem_en_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] cpu_stall_cnt_o, dbg_grant_cnt_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int grant_at;
  logic stall_at_grant;
  logic [31:0] addr_at_grant;

  always #5 clk_i = ~clk_i;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .cpu_memread_i  (cpu_memread_i),
    .cpu_memwrite_i (cpu_memwrite_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_wdata_i    (cpu_wdata_i),
    .cpu_rdata_o    (cpu_rdata_o),
    .cpu_stall_o    (cpu_stall_o),
    .dbg_valid_i    (dbg_valid_i),
    .dbg_we_i       (dbg_we_i),
    .dbg_addr_i     (dbg_addr_i),
    .dbg_wdata_i    (dbg_wdata_i),
    .dbg_ready_o    (dbg_ready_o),
    .dbg_rvalid_o   (dbg_rvalid_o),
    .dbg_rdata_o    (dbg_rdata_o),
`ifdef DMEM_ARB_STATS_EN
    .cpu_stall_cnt_o(cpu_stall_cnt_o),
    .dbg_grant_cnt_o(dbg_grant_cnt_o),
`endif
    .mem_en_o       (mem_en_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic next_cycle();
    @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0;
    cpu_memread_i = 1'b0; cpu_memwrite_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
    dbg_valid_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
    mem_rdata_i = '0;
    next_cycle(); next_cycle();
    rst_i = 1'b0;
    #1;
    chk("rst_stall", {31'd0, cpu_stall_o}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en_o}, 32'd0);
    chk("rst_dbg_ready", {31'd0, dbg_ready_o}, 32'd0);
    chk("rst_rvalid", {31'd0, dbg_rvalid_o}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata_o, 32'd0);
    chk("rst_dbg_rdata", dbg_rdata_o, 32'd0);

    // Preload write with start_i=0: CPU load request must be ignored.
    next_cycle();
    cpu_memread_i = 1'b1; cpu_addr_i = 32'h40;
    dbg_valid_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 32'h0; dbg_wdata_i = 32'd5;
    #1;
    chk("t1_ready", {31'd0, dbg_ready_o}, 32'd1);
    chk("t1_en", {31'd0, mem_en_o}, 32'd1);
    chk("t1_we", {31'd0, mem_we_o}, 32'd1);
    chk("t1_addr", mem_addr_o, 32'h0);
    chk("t1_wdata", mem_wdata_o, 32'd5);
    chk("t1_stall", {31'd0, cpu_stall_o}, 32'd0);

    // CPU load: issue cycle stalls, completion cycle returns data.
    next_cycle();
    dbg_valid_i = 1'b0; start_i = 1'b1; cpu_addr_i = 32'h4;
    #1;
    chk("t2_c0_stall", {31'd0, cpu_stall_o}, 32'd1);
    chk("t2_c0_en", {31'd0, mem_en_o}, 32'd1);
    chk("t2_c0_we", {31'd0, mem_we_o}, 32'd0);
    chk("t2_c0_addr", mem_addr_o, 32'h4);
    next_cycle();
    mem_rdata_i = 32'd8;
    #1;
    chk("t2_c1_stall", {31'd0, cpu_stall_o}, 32'd0);
    chk("t2_c1_rdata", cpu_rdata_o, 32'd8);
    chk("t2_c1_en", {31'd0, mem_en_o}, 32'd0);
    next_cycle();
    cpu_memread_i = 1'b0; mem_rdata_i = 32'h99;
    #1;
    chk("t2_hold_rdata", cpu_rdata_o, 32'd8);

    // CPU store completes in one cycle without stall.
    next_cycle();
    cpu_memwrite_i = 1'b1; cpu_addr_i = 32'h8; cpu_wdata_i = 32'd3;
    #1;
    chk("t3_stall", {31'd0, cpu_stall_o}, 32'd0);
    chk("t3_we", {31'd0, mem_we_o}, 32'd1);
    chk("t3_addr", mem_addr_o, 32'h8);
    chk("t3_wdata", mem_wdata_o, 32'd3);

    // Read and write both set is treated as a store.
    next_cycle();
    cpu_memread_i = 1'b1; cpu_addr_i = 32'h1c; cpu_wdata_i = 32'd7;
    #1;
    chk("both_we", {31'd0, mem_we_o}, 32'd1);
    chk("both_stall", {31'd0, cpu_stall_o}, 32'd0);

    // Continuous CPU loads against a waiting debug read: grant on the 5th cycle.
    next_cycle();
    cpu_memwrite_i = 1'b0; cpu_addr_i = 32'h10;
    dbg_valid_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h20;
    #1;
    chk("t4_c0_ready", {31'd0, dbg_ready_o}, 32'd0);
    chk("t4_c0_stall", {31'd0, cpu_stall_o}, 32'd1);
    grant_at = -1; stall_at_grant = 1'b0; addr_at_grant = '0;
    for (int i = 0; i < 8; i++) begin
      if (dbg_ready_o) begin
        grant_at = i; stall_at_grant = cpu_stall_o; addr_at_grant = mem_addr_o;
        break;
      end
      next_cycle();
      #1;
    end
    chk("t4_grant_cycle", grant_at, 32'd4);
    chk("t4_grant_stall", {31'd0, stall_at_grant}, 32'd1);
    chk("t4_grant_addr", addr_at_grant, 32'h20);
    next_cycle();
    dbg_valid_i = 1'b0; mem_rdata_i = 32'h77;
    #1;
    chk("t4_rvalid", {31'd0, dbg_rvalid_o}, 32'd1);
    chk("t4_dbg_rdata", dbg_rdata_o, 32'h77);
    chk("t4_rd_stall", {31'd0, cpu_stall_o}, 32'd1);
    chk("t4_rd_en", {31'd0, mem_en_o}, 32'd0);

    // Debug read interrupted by reset: the read result is discarded.
    next_cycle();
    cpu_memread_i = 1'b0; start_i = 1'b0;
    dbg_valid_i = 1'b1; dbg_addr_i = 32'hc;
    #1;
    chk("t5_ready", {31'd0, dbg_ready_o}, 32'd1);
    chk("t5_addr", mem_addr_o, 32'hc);
    next_cycle();
    dbg_valid_i = 1'b0; rst_i = 1'b1;
    next_cycle();
    rst_i = 1'b0; mem_rdata_i = 32'h55;
    #1;
    chk("t5_rvalid", {31'd0, dbg_rvalid_o}, 32'd0);
    chk("t5_en", {31'd0, mem_en_o}, 32'd0);
    chk("t5_dbg_rdata", dbg_rdata_o, 32'd0);

`ifdef DMEM_ARB_STATS_EN
    start_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      cpu_memread_i = 1'b1; cpu_addr_i = 32'h4;
      next_cycle();
      mem_rdata_i = 32'd8;
      next_cycle();
      cpu_memread_i = 1'b0;
    end
    #1;
    chk("t6_stall_cnt", {16'd0, cpu_stall_cnt_o}, 32'd3);
    chk("t6_grant_cnt", {16'd0, dbg_grant_cnt_o}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
